// File: rtl/axi_adc_jesd204_pnmon_pkg.sv
// Shared encodings for the JESD204 ADC PN/ramp test-pattern monitor.
package axi_adc_jesd204_pnmon_pkg;

  localparam logic [3:0] PNSEQ_PN9  = 4'd0;
  localparam logic [3:0] PNSEQ_PN23 = 4'd1;
  localparam logic [3:0] PNSEQ_RAMP = 4'd2;

  // Recurrence b[n] = b[n-LEN] ^ b[n-TAP] on the serial bit stream.
  localparam int unsigned PN9_LEN  = 9;
  localparam int unsigned PN9_TAP  = 5;
  localparam int unsigned PN23_LEN = 23;
  localparam int unsigned PN23_TAP = 18;

  typedef enum logic {
    ST_OOS  = 1'b0,
    ST_SYNC = 1'b1
  } pn_state_t;

  function automatic logic pnseq_enabled(input logic [3:0] sel);
    return sel <= PNSEQ_RAMP;
  endfunction

endpackage

// File: rtl/axi_adc_jesd204_pnmon_if.sv
// Channel-side signal bundle of the PN monitor: sample beats in, sync/error status out.
interface axi_adc_jesd204_pnmon_if #(
  parameter int unsigned CHANNEL_WIDTH   = 14,
  parameter int unsigned DATA_PATH_WIDTH = 4,
  parameter int unsigned ERR_CNT_WIDTH   = 16
);

  logic                                       adc_valid;
  logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0]   adc_data;
  logic [3:0]                                 adc_pnseq_sel;
  logic                                       adc_err_clr;
  logic                                       adc_pn_oos;
  logic                                       adc_pn_err;
  logic [ERR_CNT_WIDTH-1:0]                   adc_err_cnt;

  modport master (
    output adc_valid, adc_data, adc_pnseq_sel, adc_err_clr,
    input  adc_pn_oos, adc_pn_err, adc_err_cnt
  );

  modport slave (
    input  adc_valid, adc_data, adc_pnseq_sel, adc_err_clr,
    output adc_pn_oos, adc_pn_err, adc_err_cnt
  );

endinterface

// File: rtl/axi_adc_jesd204_pn_gen.sv
// Combinational next-beat predictor: advances PN9/PN23 LFSR or ramp from the previous beat.
module axi_adc_jesd204_pn_gen
  import axi_adc_jesd204_pnmon_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH   = 14,
  parameter int unsigned DATA_PATH_WIDTH = 4
) (
  input  logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0] seed,
  input  logic [3:0]                               sel,
  output logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0] expected
);

  localparam int unsigned CW = CHANNEL_WIDTH;
  localparam int unsigned W  = DATA_PATH_WIDTH * CHANNEL_WIDTH;

  logic [W-1:0]          seed_stream;
  logic [W-1:0]          pn_stream;
  logic [PN23_LEN-1:0]   lfsr;
  logic                  fb;
  logic [CW-1:0]         last;

  // Samples are repacked so bit W-1 is the first serial bit and bit 0 the newest;
  // the low bits of the repacked seed are then directly the LFSR history.
  always_comb begin
    seed_stream = '0;
    pn_stream   = '0;
    expected    = '0;
    fb          = 1'b0;
    last        = seed[CW*(DATA_PATH_WIDTH-1) +: CW];
    for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
      seed_stream[W-CW*(k+1) +: CW] = seed[CW*k +: CW];
    end
    lfsr = seed_stream[PN23_LEN-1:0];
    for (int unsigned i = 0; i < W; i++) begin
      if (sel == PNSEQ_PN9) begin
        fb = lfsr[PN9_LEN-1] ^ lfsr[PN9_TAP-1];
      end else begin
        fb = lfsr[PN23_LEN-1] ^ lfsr[PN23_TAP-1];
      end
      pn_stream[W-1-i] = fb;
      lfsr = {lfsr[PN23_LEN-2:0], fb};
    end
    case (sel)
      PNSEQ_PN9, PNSEQ_PN23: begin
        for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
          expected[CW*k +: CW] = pn_stream[W-CW*(k+1) +: CW];
        end
      end
      PNSEQ_RAMP: begin
        for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
          expected[CW*k +: CW] = last + CW'(k + 1);
        end
      end
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/axi_adc_jesd204_pnmon.sv
// Per-channel PN/ramp monitor: S1 input register, compare+FSM stage, registered status outputs.
module axi_adc_jesd204_pnmon
  import axi_adc_jesd204_pnmon_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH   = 14,
  parameter int unsigned DATA_PATH_WIDTH = 4,
  parameter int unsigned OOS_THRESHOLD   = 16,
  parameter int unsigned ERR_CNT_WIDTH   = 16
) (
  input logic                    adc_clk,
  input logic                    adc_rst,
  axi_adc_jesd204_pnmon_if.slave adc
);

  localparam int unsigned W   = DATA_PATH_WIDTH * CHANNEL_WIDTH;
  localparam logic [7:0]  THR = 8'(OOS_THRESHOLD);

  logic [W-1:0]             s1_data;
  logic                     s1_valid;
  logic [3:0]               s1_sel;
  logic [3:0]               s1_sel_prev;
  logic [W-1:0]             seed_q;
  logic [W-1:0]             exp_data;
  pn_state_t                state;
  logic [7:0]               cnt;
  logic [7:0]               cnt_inc;
  logic                     s2_err;
  logic                     match;
  logic                     flush;
  logic                     pn_oos;
  logic                     pn_err;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      s1_data     <= '0;
      s1_valid    <= 1'b0;
      s1_sel      <= '0;
      s1_sel_prev <= '0;
    end else begin
      s1_valid    <= adc.adc_valid;
      s1_sel      <= adc.adc_pnseq_sel;
      s1_sel_prev <= s1_sel;
      if (adc.adc_valid) begin
        s1_data <= adc.adc_data;
      end
    end
  end

  axi_adc_jesd204_pn_gen #(
    .CHANNEL_WIDTH   (CHANNEL_WIDTH),
    .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
  ) u_pn_gen (
    .seed     (seed_q),
    .sel      (s1_sel),
    .expected (exp_data)
  );

  // All-zero beats never count as a match so stuck lanes cannot lock.
  always_comb begin
    match   = (s1_data == exp_data) && (|s1_data);
    flush   = (s1_sel != s1_sel_prev) || !pnseq_enabled(s1_sel);
    cnt_inc = cnt + 8'd1;
  end

  // Seed tracks received data while hunting, the prediction once locked, so a
  // corrupted beat in sync does not derail the following predictions.
  always_ff @(posedge adc_clk) begin
    if (adc_rst || flush) begin
      state  <= ST_OOS;
      cnt    <= '0;
      s2_err <= 1'b0;
      seed_q <= '0;
    end else begin
      s2_err <= 1'b0;
      if (s1_valid) begin
        seed_q <= (state == ST_SYNC) ? exp_data : s1_data;
        case (state)
          ST_OOS: begin
            if (!match) begin
              cnt <= '0;
            end else if (cnt_inc == THR) begin
              state <= ST_SYNC;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_SYNC: begin
            s2_err <= !match;
            if (match) begin
              cnt <= '0;
            end else if (cnt_inc == THR) begin
              state <= ST_OOS;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= ST_OOS;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      pn_oos  <= 1'b1;
      pn_err  <= 1'b0;
      err_cnt <= '0;
    end else begin
      pn_oos <= (state == ST_OOS);
      pn_err <= s2_err;
      if (adc.adc_err_clr) begin
        err_cnt <= '0;
      end else if (s2_err && !(&err_cnt)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign adc.adc_pn_oos  = pn_oos;
  assign adc.adc_pn_err  = pn_err;
  assign adc.adc_err_cnt = err_cnt;

endmodule

// File: tb/tb_axi_adc_jesd204_pnmon.sv
// Randomized bench for axi_adc_jesd204_pnmon against a bit-stream level reference model.
module tb_axi_adc_jesd204_pnmon;

  localparam int CW  = 14;
  localparam int DPW = 4;
  localparam int W   = CW * DPW;
  localparam int THR = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid;
  logic [W-1:0]   data;
  logic [3:0]     sel;
  logic           clr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  axi_adc_jesd204_pnmon_if #(.CHANNEL_WIDTH(CW), .DATA_PATH_WIDTH(DPW), .ERR_CNT_WIDTH(16)) bus16 ();
  axi_adc_jesd204_pnmon_if #(.CHANNEL_WIDTH(CW), .DATA_PATH_WIDTH(DPW), .ERR_CNT_WIDTH(4))  bus4  ();

  assign bus16.adc_valid = valid;  assign bus4.adc_valid = valid;
  assign bus16.adc_data  = data;   assign bus4.adc_data  = data;
  assign bus16.adc_pnseq_sel = sel; assign bus4.adc_pnseq_sel = sel;
  assign bus16.adc_err_clr = clr;  assign bus4.adc_err_clr = clr;

  axi_adc_jesd204_pnmon #(
    .CHANNEL_WIDTH(CW), .DATA_PATH_WIDTH(DPW), .OOS_THRESHOLD(THR), .ERR_CNT_WIDTH(16)
  ) dut16 (.adc_clk(clk), .adc_rst(rst), .adc(bus16));

  axi_adc_jesd204_pnmon #(
    .CHANNEL_WIDTH(CW), .DATA_PATH_WIDTH(DPW), .OOS_THRESHOLD(THR), .ERR_CNT_WIDTH(4)
  ) dut4 (.adc_clk(clk), .adc_rst(rst), .adc(bus4));

  always #5 clk = ~clk;

  // Reference model state
  logic         m_sync;
  int           m_run;
  logic [W-1:0] m_seed;
  logic [3:0]   m_prev_sel;
  logic         d_oos [2];
  logic         d_err [2];
  logic         x_oos, x_err;
  int           x_c16, x_c4;
  logic [W-1:0] gen_word;

  // Expected next beat derived from serial-stream rules (sample 0 first, MSB first).
  function automatic logic [W-1:0] model_expected(input logic [W-1:0] seed, input logic [3:0] s);
    logic [W-1:0]  r;
    bit            b [0:2*W-1];
    int            l, t, v;
    logic [CW-1:0] last;
    r = '0;
    if (s == 4'd2) begin
      last = seed[CW*(DPW-1) +: CW];
      for (int k = 0; k < DPW; k++) begin
        v = (int'(last) + k + 1) % (1 << CW);
        r[CW*k +: CW] = v[CW-1:0];
      end
    end else if (s <= 4'd1) begin
      l = (s == 4'd0) ? 9 : 23;
      t = (s == 4'd0) ? 5 : 18;
      for (int i = 0; i < W; i++) b[i] = seed[(i / CW) * CW + CW - 1 - i % CW];
      for (int n = W; n < 2 * W; n++) b[n] = b[n-l] ^ b[n-t];
      for (int i = 0; i < W; i++) r[(i / CW) * CW + CW - 1 - i % CW] = b[W+i];
    end
    return r;
  endfunction

  task automatic model_step(input logic v, input logic [W-1:0] d, input logic [3:0] s,
                            output logic o_oos, output logic o_err);
    logic [W-1:0] e;
    logic         m;
    logic         fl;
    fl = (s != m_prev_sel) || (s > 4'd2);
    m_prev_sel = s;
    o_err = 1'b0;
    if (fl) begin
      m_sync = 1'b0; m_run = 0; m_seed = '0;
    end else if (v) begin
      e = model_expected(m_seed, s);
      m = (d == e) && (d != '0);
      o_err = m_sync && !m;
      m_seed = m_sync ? e : d;
      if (!m_sync) m_run = m ? m_run + 1 : 0;
      else         m_run = m ? 0 : m_run + 1;
      if (m_run == THR) begin
        m_sync = !m_sync;
        m_run  = 0;
      end
    end
    o_oos = !m_sync;
  endtask

  // Expected outputs after the coming edge; beat effects surface two edges later.
  task automatic model_advance();
    logic no, ne;
    if (rst) begin
      m_sync = 1'b0; m_run = 0; m_seed = '0; m_prev_sel = '0;
      d_oos[0] = 1'b1; d_oos[1] = 1'b1; d_err[0] = 1'b0; d_err[1] = 1'b0;
      x_oos = 1'b1; x_err = 1'b0; x_c16 = 0; x_c4 = 0;
    end else begin
      model_step(valid, data, sel, no, ne);
      x_oos = d_oos[0]; x_err = d_err[0];
      d_oos[0] = d_oos[1]; d_err[0] = d_err[1];
      d_oos[1] = no;       d_err[1] = ne;
      if (clr) begin
        x_c16 = 0; x_c4 = 0;
      end else if (x_err) begin
        if (x_c16 < 65535) x_c16++;
        if (x_c4 < 15) x_c4++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
    chk("pn_oos", 64'(bus16.adc_pn_oos), 64'(x_oos));
    chk("pn_err", 64'(bus16.adc_pn_err), 64'(x_err));
    chk("err_cnt16", 64'(bus16.adc_err_cnt), 64'(x_c16));
    chk("err_cnt4", 64'(bus4.adc_err_cnt), 64'(x_c4));
    cyc++;
  endtask

  task automatic drive(input logic [3:0] s, input logic v, input logic [W-1:0] d);
    sel = s; valid = v; data = d;
    tick();
  endtask

  task automatic gen_beat(input logic [3:0] s, input logic [3:0] gsel, input logic v, input logic flip);
    logic [W-1:0] d;
    logic [W-1:0] mask;
    if (v) begin
      gen_word = model_expected(gen_word, gsel);
      d = gen_word;
      if (flip) begin
        mask = '0;
        mask[$urandom_range(W-1, 0)] = 1'b1;
        d = d ^ mask;
      end
    end else begin
      d = {$urandom, $urandom};
    end
    drive(s, v, d);
  endtask

  logic [W-1:0] w, sd;
  int e0, e_fall, nvalid;
  logic pv;

  initial begin
    rst = 1'b1; valid = 1'b0; data = '0; sel = 4'd0; clr = 1'b0;
    repeat (3) tick();
    chk("rst_oos", 64'(bus16.adc_pn_oos), 64'd1);
    chk("rst_err", 64'(bus16.adc_pn_err), 64'd0);
    chk("rst_cnt", 64'(bus16.adc_err_cnt), 64'd0);
    rst = 1'b0;
    repeat (2) drive(4'd0, 1'b0, '0);

    // Pin the model with hand-derived words.
    w = model_expected('1, 4'd0);
    chk("pin_pn9_s0", 64'(w[CW-1:0]), 64'h1EF);
    sd = '0; sd[CW*3 +: CW] = 14'h3FFF;
    w = model_expected(sd, 4'd2);
    chk("pin_ramp_wrap", 64'(w), 64'({14'd3, 14'd2, 14'd1, 14'd0}));

    // PN9 lock timing
    gen_word = {$urandom, $urandom};
    gen_word[CW*3] = 1'b1;
    e0 = cyc; e_fall = -1;
    for (int i = 0; i < 30; i++) begin
      gen_beat(4'd0, 4'd0, 1'b1, 1'b0);
      if (!bus16.adc_pn_oos && e_fall < 0) e_fall = cyc - 1;
    end
    chk("pn9_lock_latency", 64'(e_fall - e0), 64'd18);

    // Single bit error in sync
    gen_beat(4'd0, 4'd0, 1'b1, 1'b1);
    repeat (6) gen_beat(4'd0, 4'd0, 1'b1, 1'b0);
    chk("single_err_cnt", 64'(bus16.adc_err_cnt), 64'd1);
    chk("single_err_oos", 64'(bus16.adc_pn_oos), 64'd0);

    // 16 corrupted beats drop sync
    repeat (16) gen_beat(4'd0, 4'd0, 1'b1, 1'b1);
    repeat (2) drive(4'd0, 1'b0, '0);
    chk("burst_oos", 64'(bus16.adc_pn_oos), 64'd1);
    chk("burst_cnt", 64'(bus16.adc_err_cnt), 64'd17);
    repeat (25) gen_beat(4'd0, 4'd0, 1'b1, 1'b0);

    // All-zero beats on PN23 never lock, then clean PN23 does
    repeat (40) drive(4'd1, 1'b1, '0);
    chk("zero_no_lock", 64'(bus16.adc_pn_oos), 64'd1);
    gen_word = {$urandom, $urandom};
    gen_word[CW*3] = 1'b1;
    repeat (30) gen_beat(4'd1, 4'd1, 1'b1, 1'b0);
    chk("pn23_lock", 64'(bus16.adc_pn_oos), 64'd0);

    // Ramp with random gaps, crossing the wrap point
    gen_word = '0;
    gen_word[CW*3 +: CW] = 14'h3F80;
    nvalid = 0;
    for (int i = 0; i < 400 && nvalid < 50; i++) begin
      pv = 1'($urandom_range(1, 0));
      gen_beat(4'd2, 4'd2, pv, 1'b0);
      if (pv) nvalid++;
    end
    chk("ramp_lock", 64'(bus16.adc_pn_oos), 64'd0);
    chk("ramp_wrapped", 64'(gen_word[CW*3 +: CW] < 14'h3F80), 64'd1);

    // Saturation on the narrow counter
    clr = 1'b1; drive(4'd2, 1'b0, '0); clr = 1'b0;
    chk("clr_cnt", 64'(bus16.adc_err_cnt), 64'd0);
    repeat (20) begin
      gen_beat(4'd2, 4'd2, 1'b1, 1'b1);
      gen_beat(4'd2, 4'd2, 1'b1, 1'b0);
    end
    repeat (2) drive(4'd2, 1'b0, '0);
    chk("sat_cnt16", 64'(bus16.adc_err_cnt), 64'd20);
    chk("sat_cnt4", 64'(bus4.adc_err_cnt), 64'd15);
    chk("sat_oos", 64'(bus16.adc_pn_oos), 64'd0);

    // Clear coincident with an error pulse
    gen_beat(4'd2, 4'd2, 1'b1, 1'b1);
    gen_beat(4'd2, 4'd2, 1'b1, 1'b0);
    clr = 1'b1;
    gen_beat(4'd2, 4'd2, 1'b1, 1'b0);
    clr = 1'b0;
    chk("clr_vs_err_pulse", 64'(bus16.adc_pn_err), 64'd1);
    chk("clr_vs_err_cnt", 64'(bus16.adc_err_cnt), 64'd0);
    repeat (2) gen_beat(4'd2, 4'd2, 1'b1, 1'b0);
    chk("clr_hold", 64'(bus16.adc_err_cnt), 64'd0);

    // Pattern change while locked
    drive(4'd0, 1'b0, '0);
    drive(4'd0, 1'b0, '0);
    drive(4'd0, 1'b0, '0);
    chk("sel_change_oos", 64'(bus16.adc_pn_oos), 64'd1);

    // Off holds out of sync even with clean data
    repeat (20) gen_beat(4'd7, 4'd2, 1'b1, 1'b0);
    chk("off_oos", 64'(bus16.adc_pn_oos), 64'd1);
    repeat (25) gen_beat(4'd2, 4'd2, 1'b1, 1'b0);
    chk("relock", 64'(bus16.adc_pn_oos), 64'd0);

    // Reset with an error in flight
    gen_beat(4'd2, 4'd2, 1'b1, 1'b1);
    rst = 1'b1;
    drive(4'd2, 1'b0, '0);
    rst = 1'b0;
    chk("midrst_oos", 64'(bus16.adc_pn_oos), 64'd1);
    chk("midrst_cnt", 64'(bus16.adc_err_cnt), 64'd0);
    drive(4'd2, 1'b0, '0);
    chk("midrst_no_pulse", 64'(bus16.adc_pn_err), 64'd0);
    repeat (4) drive(4'd2, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
